// File: rtl/hit_store_pkg.sv
// Shared types for the hit bitmap store: FSM states, drain targets and
// the index-width helper used to derive default parameter values.
package hit_store_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_ACCUM,
    ST_DRAIN,
    ST_READOUT
  } state_e;

  typedef enum logic {
    DRAIN_TO_READ,
    DRAIN_TO_CLEAR
  } drain_tgt_e;

  function automatic int unsigned index_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bitmap_ram_dp.sv
// Dual-port bitmap storage: port A writes, port B reads with one cycle of
// latency and returns the pre-write contents on a same-address collision.
module bitmap_ram_dp
  import hit_store_pkg::*;
#(
  parameter int unsigned NROWS        = 16,
  parameter int unsigned WORDLENGTH   = 16,
  parameter int unsigned ROWINDEXBITS = index_bits(NROWS)
) (
  input  logic                    clock,
  input  logic                    a_we,
  input  logic [ROWINDEXBITS-1:0] a_addr,
  input  logic [WORDLENGTH-1:0]   a_wdata,
  input  logic                    b_en,
  input  logic [ROWINDEXBITS-1:0] b_addr,
  output logic [WORDLENGTH-1:0]   b_rdata
);

  // NOTE: the array has no reset; the owner zeroes it row by row after reset.
  logic [WORDLENGTH-1:0] mem [NROWS];
  logic [WORDLENGTH-1:0] b_rdata_q;

  always_ff @(posedge clock) begin
    if (a_we) mem[a_addr] <= a_wdata;
  end

  // Output register holds while b_en is low, which the readout uses as its stall.
  always_ff @(posedge clock) begin
    if (b_en) b_rdata_q <= mem[b_addr];
  end

  assign b_rdata = b_rdata_q;

endmodule

// File: rtl/hit_bitmap_store.sv
// Hit bitmap store: accumulates (row, col) hits by read-modify-write,
// clears on command and streams the bitmap out row by row.
module hit_bitmap_store
  import hit_store_pkg::*;
#(
  parameter int unsigned NROWS         = 16,
  parameter int unsigned WORDLENGTH    = 16,
  parameter int unsigned ROWINDEXBITS  = index_bits(NROWS),
  parameter int unsigned COLINDEXBITS  = index_bits(WORDLENGTH),
  parameter bit          CLEAR_ON_READ = 1'b0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    hit_valid,
  output logic                    hit_ready,
  input  logic [ROWINDEXBITS-1:0] hit_row,
  input  logic [COLINDEXBITS-1:0] hit_col,
  input  logic                    clear_start,
  input  logic                    read_start,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [WORDLENGTH-1:0]   rd_data,
  output logic [ROWINDEXBITS-1:0] rd_row,
  output logic                    rd_last,
  output logic                    busy
);

  localparam int unsigned IDXW = ROWINDEXBITS + 1;

  typedef logic [WORDLENGTH-1:0]   word_t;
  typedef logic [ROWINDEXBITS-1:0] row_t;
  typedef logic [IDXW-1:0]         idx_t;

  state_e     state_q, state_d;
  drain_tgt_e tgt_q, tgt_d;
  idx_t       idx_q, idx_d;

  logic  s1_valid_q, s1_valid_d;
  row_t  s1_row_q, s1_row_d;
  word_t s1_mask_q, s1_mask_d;
  logic  s1_byp_q, s1_byp_d;
  word_t s1_byp_data_q, s1_byp_data_d;
  logic  s2_valid_q, s2_valid_d;
  row_t  s2_row_q, s2_row_d;
  word_t s2_data_q, s2_data_d;

  logic rd_valid_q, rd_valid_d;
  row_t rd_row_q, rd_row_d;
  logic rd_last_q, rd_last_d;

  logic  ram_a_we, ram_b_en;
  row_t  ram_a_addr, ram_b_addr;
  word_t ram_a_wdata, ram_b_rdata;

  logic  rd_issue, rd_fire, pipe_empty;
  logic  hit_take, hit_merge, hit_bypass, hit_alloc;
  word_t hit_mask, s1_base;

  // NOTE: state updates use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_CLEAR;
      tgt_q         <= DRAIN_TO_READ;
      idx_q         <= '0;
      s1_valid_q    <= 1'b0;
      s1_row_q      <= '0;
      s1_mask_q     <= '0;
      s1_byp_q      <= 1'b0;
      s1_byp_data_q <= '0;
      s2_valid_q    <= 1'b0;
      s2_row_q      <= '0;
      s2_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      rd_row_q      <= '0;
      rd_last_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      tgt_q         <= tgt_d;
      idx_q         <= idx_d;
      s1_valid_q    <= s1_valid_d;
      s1_row_q      <= s1_row_d;
      s1_mask_q     <= s1_mask_d;
      s1_byp_q      <= s1_byp_d;
      s1_byp_data_q <= s1_byp_data_d;
      s2_valid_q    <= s2_valid_d;
      s2_row_q      <= s2_row_d;
      s2_data_q     <= s2_data_d;
      rd_valid_q    <= rd_valid_d;
      rd_row_q      <= rd_row_d;
      rd_last_q     <= rd_last_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    idx_d       = idx_q;
    rd_valid_d  = rd_valid_q;
    rd_row_d    = rd_row_q;
    rd_last_d   = rd_last_q;
    hit_ready   = 1'b0;
    rd_issue    = 1'b0;
    ram_a_we    = 1'b0;
    ram_a_addr  = s2_row_q;
    ram_a_wdata = s2_data_q;
    pipe_empty  = !s1_valid_q && !s2_valid_q;
    rd_fire     = rd_valid_q && rd_ready;

    unique case (state_q)
      ST_CLEAR: begin
        ram_a_we    = 1'b1;
        ram_a_addr  = row_t'(idx_q);
        ram_a_wdata = '0;
        if (idx_q == idx_t'(NROWS - 1)) begin
          state_d = ST_ACCUM;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + idx_t'(1);
        end
      end
      ST_ACCUM: begin
        hit_ready = 1'b1;
        ram_a_we  = s2_valid_q;
        if (clear_start) begin
          state_d = ST_DRAIN;
          tgt_d   = DRAIN_TO_CLEAR;
        end else if (read_start) begin
          state_d = ST_DRAIN;
          tgt_d   = DRAIN_TO_READ;
        end
      end
      ST_DRAIN: begin
        ram_a_we = s2_valid_q;
        if (pipe_empty) begin
          state_d = (tgt_q == DRAIN_TO_CLEAR) ? ST_CLEAR : ST_READOUT;
          idx_d   = '0;
        end
      end
      ST_READOUT: begin
        // Prefetch the next row whenever the output slot frees up this cycle.
        if (!rd_valid_q || rd_ready) begin
          rd_issue   = idx_q < idx_t'(NROWS);
          rd_valid_d = rd_issue;
          if (rd_issue) begin
            rd_row_d  = row_t'(idx_q);
            rd_last_d = (idx_q == idx_t'(NROWS - 1));
            idx_d     = idx_q + idx_t'(1);
          end
        end
        if (rd_fire && rd_last_q) state_d = ST_ACCUM;
        if (CLEAR_ON_READ && rd_fire) begin
          ram_a_we    = 1'b1;
          ram_a_addr  = rd_row_q;
          ram_a_wdata = '0;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // RMW pipeline: a hit to the row in S1 folds into S1; a hit to the row being
  // written takes the write data instead of the stale RAM read.
  always_comb begin
    hit_take   = hit_valid && hit_ready && (idx_t'(hit_row) < idx_t'(NROWS));
    hit_mask   = word_t'(1) << hit_col;
    hit_merge  = hit_take && s1_valid_q && (hit_row == s1_row_q);
    hit_bypass = hit_take && s2_valid_q && (hit_row == s2_row_q);
    hit_alloc  = hit_take && !hit_merge;

    s1_valid_d    = hit_alloc;
    s1_row_d      = hit_row;
    s1_mask_d     = hit_mask;
    s1_byp_d      = hit_bypass;
    s1_byp_data_d = s2_data_q;

    s1_base    = s1_byp_q ? s1_byp_data_q : ram_b_rdata;
    s2_valid_d = s1_valid_q;
    s2_row_d   = s1_row_q;
    s2_data_d  = s1_base | s1_mask_q | (hit_merge ? hit_mask : '0);

    ram_b_en   = rd_issue || hit_alloc;
    ram_b_addr = rd_issue ? row_t'(idx_q) : hit_row;
  end

  bitmap_ram_dp #(
    .NROWS       (NROWS),
    .WORDLENGTH  (WORDLENGTH),
    .ROWINDEXBITS(ROWINDEXBITS)
  ) u_ram (
    .clock  (clock),
    .a_we   (ram_a_we),
    .a_addr (ram_a_addr),
    .a_wdata(ram_a_wdata),
    .b_en   (ram_b_en),
    .b_addr (ram_b_addr),
    .b_rdata(ram_b_rdata)
  );

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_valid_q ? ram_b_rdata : '0;
  assign rd_row   = rd_row_q;
  assign rd_last  = rd_valid_q && rd_last_q;
  assign busy     = (state_q != ST_ACCUM);

endmodule

// File: tb/tb_hit_bitmap_store.sv
// Directed bench for hit_bitmap_store: one instance without and one with
// clear-on-read, driven by the same stimulus and checked against bitmap models.
module tb_hit_bitmap_store;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        hit_valid = 1'b0;
  logic [3:0]  hit_row = '0;
  logic [3:0]  hit_col = '0;
  logic        clear_start = 1'b0;
  logic        read_start = 1'b0;
  logic        rd_ready = 1'b0;

  logic        hit_ready, rd_valid, rd_last, busy;
  logic [15:0] rd_data;
  logic [3:0]  rd_row;
  logic        c_hit_ready, c_rd_valid, c_rd_last, c_busy;
  logic [15:0] c_rd_data;
  logic [3:0]  c_rd_row;

  int          n_assert = 0;
  int          n_fail = 0;
  logic [15:0] exp_a [16];
  logic [15:0] exp_c [16];

  hit_bitmap_store #(.NROWS(16), .WORDLENGTH(16), .CLEAR_ON_READ(1'b0)) dut (
    .clock(clock), .reset(reset), .hit_valid(hit_valid), .hit_ready(hit_ready),
    .hit_row(hit_row), .hit_col(hit_col), .clear_start(clear_start),
    .read_start(read_start), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_row(rd_row), .rd_last(rd_last), .busy(busy)
  );

  hit_bitmap_store #(.NROWS(16), .WORDLENGTH(16), .CLEAR_ON_READ(1'b1)) dut_cor (
    .clock(clock), .reset(reset), .hit_valid(hit_valid), .hit_ready(c_hit_ready),
    .hit_row(hit_row), .hit_col(hit_col), .clear_start(clear_start),
    .read_start(read_start), .rd_valid(c_rd_valid), .rd_ready(rd_ready),
    .rd_data(c_rd_data), .rd_row(c_rd_row), .rd_last(c_rd_last), .busy(c_busy)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic zero_models();
    for (int i = 0; i < 16; i++) begin
      exp_a[i] = '0;
      exp_c[i] = '0;
    end
  endtask

  // Caller is at a negedge; reset is held for the given number of cycles.
  task automatic do_reset(input int cycles);
    int  busy_cnt;
    bit  saw_valid;
    reset = 1'b1;
    hit_valid = 1'b0;
    clear_start = 1'b0;
    read_start = 1'b0;
    repeat (cycles) @(negedge clock);
    check("rst_hit_ready", hit_ready, 0);
    check("rst_busy", busy, 1);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_row", rd_row, 0);
    check("rst_rd_last", rd_last, 0);
    check("rst_cor_ctrl", {c_hit_ready, c_busy, c_rd_valid}, 3'b010);
    reset = 1'b0;
    busy_cnt = 1;
    saw_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (rd_valid || c_rd_valid) saw_valid = 1'b1;
      if (!busy) break;
      busy_cnt++;
    end
    check("clr_busy_cycles", busy_cnt, 16);
    check("clr_hit_ready", hit_ready, 1);
    check("clr_no_rd_valid", saw_valid, 0);
    zero_models();
  endtask

  task automatic send_hit(input logic [3:0] r, input logic [3:0] c,
                          input bit with_read, input bit with_clear);
    @(negedge clock);
    check("hit_ready", hit_ready, 1);
    hit_valid = 1'b1;
    hit_row = r;
    hit_col = c;
    read_start = with_read;
    clear_start = with_clear;
    exp_a[r] = exp_a[r] | (16'd1 << c);
    exp_c[r] = exp_c[r] | (16'd1 << c);
  endtask

  // Streams the whole bitmap; toggle selects rd_ready pattern 1,0,0,1.
  task automatic do_read(input bit pulse, input bit toggle);
    logic [3:0] pat;
    int idx;
    int cyc;
    pat = 4'b1001;
    if (pulse) begin
      @(negedge clock);
      hit_valid = 1'b0;
      read_start = 1'b1;
    end
    idx = 0;
    cyc = 0;
    while (idx < 16 && cyc < 200) begin
      @(negedge clock);
      hit_valid = 1'b0;
      read_start = 1'b0;
      clear_start = 1'b0;
      rd_ready = toggle ? pat[cyc % 4] : 1'b1;
      if (rd_valid) begin
        check("rd_row", rd_row, idx);
        check("rd_data", rd_data, exp_a[idx]);
        check("rd_last", rd_last, (idx == 15) ? 1 : 0);
        check("cor_rd_row_valid", {c_rd_valid, c_rd_row}, {1'b1, 4'(idx)});
        check("cor_rd_data", c_rd_data, exp_c[idx]);
        check("cor_rd_last", c_rd_last, (idx == 15) ? 1 : 0);
        if (rd_ready) idx++;
      end
      cyc++;
    end
    check("rd_row_count", idx, 16);
    @(negedge clock);
    rd_ready = 1'b0;
    check("rd_done_valid", rd_valid, 0);
    check("rd_done_busy", busy, 0);
    for (int i = 0; i < 16; i++) exp_c[i] = '0;
  endtask

  initial begin
    int  cyc;
    int  busy_cnt;
    bit  saw_valid;
    zero_models();

    // 1: reset, clear sweep, all-zero readout
    do_reset(2);
    do_read(1'b1, 1'b0);

    // 2: three hits to one row at full rate
    send_hit(4'd3, 4'd0, 1'b0, 1'b0);
    send_hit(4'd3, 4'd5, 1'b0, 1'b0);
    send_hit(4'd3, 4'd15, 1'b0, 1'b0);
    check("model_row3", exp_a[3], 16'h8021);
    do_read(1'b1, 1'b0);

    // 3: alternating rows exercise the write bypass; last hit rides the read pulse
    send_hit(4'd2, 4'd1, 1'b0, 1'b0);
    send_hit(4'd7, 4'd1, 1'b0, 1'b0);
    send_hit(4'd2, 4'd2, 1'b0, 1'b0);
    send_hit(4'd7, 4'd2, 1'b1, 1'b0);
    check("model_row2_row7", {exp_a[2], exp_a[7]}, {16'h0006, 16'h0006});
    do_read(1'b0, 1'b0);

    // 4: corner rows, duplicate hit, stalled readout
    send_hit(4'd0, 4'd0, 1'b0, 1'b0);
    send_hit(4'd15, 4'd15, 1'b0, 1'b0);
    send_hit(4'd9, 4'd3, 1'b0, 1'b0);
    send_hit(4'd9, 4'd3, 1'b0, 1'b0);
    do_read(1'b1, 1'b1);

    // 5: clear-on-read empties the second instance after one pass
    send_hit(4'd5, 4'd4, 1'b0, 1'b0);
    check("model_cor_row5", exp_c[5], 16'h0010);
    do_read(1'b1, 1'b0);
    do_read(1'b1, 1'b0);

    // 6a: reset while row 8 is being presented
    @(negedge clock);
    read_start = 1'b1;
    cyc = 0;
    while (cyc < 50) begin
      @(negedge clock);
      read_start = 1'b0;
      rd_ready = 1'b1;
      if (rd_valid && rd_row == 4'd8) break;
      cyc++;
    end
    check("rst6_at_row8", {rd_valid, rd_row}, {1'b1, 4'd8});
    do_reset(1);
    rd_ready = 1'b0;
    do_read(1'b1, 1'b0);

    // 6b: clear and read pulses together, with a hit in the same cycle
    send_hit(4'd1, 4'd1, 1'b1, 1'b1);
    busy_cnt = 0;
    saw_valid = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      hit_valid = 1'b0;
      read_start = 1'b0;
      clear_start = 1'b0;
      if (rd_valid || c_rd_valid) saw_valid = 1'b1;
      if (!busy) break;
      busy_cnt++;
    end
    check("clr6_busy_ge16", (busy_cnt >= 16) ? 1 : 0, 1);
    check("clr6_busy_bounded", (busy_cnt < 60) ? 1 : 0, 1);
    check("clr6_no_rd_valid", saw_valid, 0);
    zero_models();
    repeat (3) @(negedge clock);
    check("clr6_read_dropped", {rd_valid, busy}, 2'b00);
    do_read(1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
